// File: rtl/sr_flip_flop_gate.sv
// Single-bit rising-edge set/reset flip-flop.
// s=r=1 holds; q_bar is always the complement of q.
module sr_flip_flop_gate (
  input  logic clk,
  input  logic rst,
  input  logic s,
  input  logic r,
  output logic q,
  output logic q_bar
);

  logic state_q;
  logic state_d;

  // next state: set, clear, or hold (idle and forbidden both hold)
  always_comb begin
    state_d = state_q;
    unique case ({s, r})
      2'b10:   state_d = 1'b1;
      2'b01:   state_d = 1'b0;
      default: state_d = state_q;
    endcase
  end

  // state register with synchronous reset taking priority
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= 1'b0;
    end else begin
      state_q <= state_d;
    end
  end

  assign q     = state_q;
  assign q_bar = ~state_q;

endmodule

// File: tb/tb_sr_flip_flop_gate.sv
// Self-checking bench for sr_flip_flop_gate.
// Directed scenarios plus randomized traffic against a table model.
module tb_sr_flip_flop_gate;

  logic clk;
  logic rst;
  logic s;
  logic r;
  logic q;
  logic q_bar;

  int total;
  int bad;
  logic mq;

  sr_flip_flop_gate dut (
    .clk  (clk),
    .rst  (rst),
    .s    (s),
    .r    (r),
    .q    (q),
    .q_bar(q_bar)
  );

  initial clk = 1'b0;
  always #10 clk = ~clk;

  function automatic logic model_next(
    input logic cur,
    input logic rs,
    input logic ss,
    input logic rr
  );
    if (rs) return 1'b0;
    if (ss && !rr) return 1'b1;
    if (rr && !ss) return 1'b0;
    return cur;
  endfunction

  // change inputs midway between rising edges
  task automatic drive(input logic rs, input logic ss, input logic rr);
    @(negedge clk);
    rst = rs;
    s   = ss;
    r   = rr;
  endtask

  // advance past one rising edge and update the model
  task automatic tick();
    @(posedge clk);
    #1;
    mq = model_next(mq, rst, s, r);
  endtask

  task automatic test_reset();
    drive(1'b1, 1'b1, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (q !== 1'b0 || q_bar !== 1'b1) begin
        bad++;
        $display("FAIL reset_hold: q=%b q_bar=%b want q=0 q_bar=1", q, q_bar);
      end
    end
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 2; i++) begin
      tick();
      total++;
      if (q !== 1'b0 || q_bar !== 1'b1) begin
        bad++;
        $display("FAIL reset_release: q=%b q_bar=%b want q=0 q_bar=1", q, q_bar);
      end
    end
  endtask

  task automatic test_set_clear_hold();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    total++;
    if (q !== 1'b1 || q_bar !== 1'b0) begin
      bad++;
      $display("FAIL set: q=%b q_bar=%b want q=1 q_bar=0", q, q_bar);
    end
    drive(1'b0, 1'b0, 1'b0);
    for (int i = 0; i < 3; i++) begin
      tick();
      total++;
      if (q !== 1'b1 || q_bar !== 1'b0) begin
        bad++;
        $display("FAIL hold: q=%b q_bar=%b want q=1 q_bar=0", q, q_bar);
      end
    end
    drive(1'b0, 1'b0, 1'b1);
    tick();
    total++;
    if (q !== 1'b0 || q_bar !== 1'b1) begin
      bad++;
      $display("FAIL clear: q=%b q_bar=%b want q=0 q_bar=1", q, q_bar);
    end
  endtask

  task automatic test_forbidden();
    logic want;
    for (int k = 0; k < 2; k++) begin
      want = (k == 0) ? 1'b1 : 1'b0;
      drive(1'b0, want, ~want);
      tick();
      drive(1'b0, 1'b1, 1'b1);
      for (int i = 0; i < 3; i++) begin
        tick();
        total++;
        if (q !== want || q_bar !== ~want || q === q_bar) begin
          bad++;
          $display("FAIL forbidden_hold: q=%b q_bar=%b want q=%b q_bar=%b",
                   q, q_bar, want, ~want);
        end
      end
    end
  endtask

  task automatic test_edge_sensitivity();
    drive(1'b0, 1'b0, 1'b1);
    tick();
    drive(1'b0, 1'b0, 1'b0);
    tick();
    @(negedge clk);
    #1 s = 1'b1;
    #8 s = 1'b0;
    total++;
    if (q !== 1'b0 || q_bar !== 1'b1) begin
      bad++;
      $display("FAIL pulse_mid: q=%b q_bar=%b want q=0 q_bar=1", q, q_bar);
    end
    tick();
    total++;
    if (q !== 1'b0 || q_bar !== 1'b1) begin
      bad++;
      $display("FAIL pulse_edge: q=%b q_bar=%b want q=0 q_bar=1", q, q_bar);
    end
  endtask

  task automatic test_sync_reset();
    drive(1'b0, 1'b1, 1'b0);
    tick();
    @(negedge clk);
    s = 1'b0;
    @(posedge clk);
    mq = model_next(mq, rst, s, r);
    #5 rst = 1'b1;
    #4;
    total++;
    if (q !== 1'b1 || q_bar !== 1'b0) begin
      bad++;
      $display("FAIL rst_between_edges: q=%b want 1", q);
    end
    tick();
    total++;
    if (q !== 1'b0 || q_bar !== 1'b1) begin
      bad++;
      $display("FAIL rst_at_edge: q=%b want 0", q);
    end
    drive(1'b0, 1'b1, 1'b0);
    tick();
    total++;
    if (q !== 1'b1 || q_bar !== 1'b0) begin
      bad++;
      $display("FAIL rst_release_set: q=%b want 1", q);
    end
  endtask

  task automatic test_sequence();
    logic [1:0] stim [8];
    logic       want [8];
    stim = '{2'b00, 2'b01, 2'b10, 2'b11, 2'b00, 2'b10, 2'b01, 2'b11};
    want = '{1'b0, 1'b0, 1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b0};
    drive(1'b1, 1'b0, 1'b0);
    tick();
    for (int i = 0; i < 8; i++) begin
      drive(1'b0, stim[i][1], stim[i][0]);
      for (int e = 0; e < 2 + (i % 2); e++) begin
        tick();
        total++;
        if (q !== want[i] || q_bar !== ~want[i]) begin
          bad++;
          $display("FAIL seq_step%0d: q=%b q_bar=%b want q=%b",
                   i, q, q_bar, want[i]);
        end
      end
    end
  endtask

  task automatic test_random();
    for (int i = 0; i < 300; i++) begin
      drive(($urandom_range(0, 15) == 0), $urandom_range(0, 1),
            $urandom_range(0, 1));
      tick();
      total++;
      if (q !== mq || q_bar !== ~mq || q === q_bar) begin
        bad++;
        $display("FAIL random%0d: rst=%b s=%b r=%b q=%b q_bar=%b want q=%b",
                 i, rst, s, r, q, q_bar, mq);
      end
    end
  endtask

  initial begin
    total = 0;
    bad   = 0;
    mq    = 1'bx;
    rst   = 1'b0;
    s     = 1'b0;
    r     = 1'b0;
    test_reset();
    test_set_clear_hold();
    test_forbidden();
    test_edge_sensitivity();
    test_sync_reset();
    test_sequence();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
